// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: sequencer state
// encoding and the default byte width of the uart_tx serializer.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and serializer-side signals of the UART
// transmit arbiter. master = clients + uart_tx side, slave = arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic                      arb_busy;

    modport master (
        output req, req_data, req_last, tx_busy,
        input  grant, ack, tx_data, tx_start, arb_busy
    );

    modport slave (
        input  req, req_data, req_last, tx_busy,
        output grant, ack, tx_data, tx_start, arb_busy
    );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches req_i starting at ptr_i+1
// (wrapping modulo NUM_REQ); the first set bit wins.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Rotating priority search; ptr_i itself is examined last.
    always_comb begin
        int               k;
        logic [IDX_W-1:0] k_idx;
        logic             found;
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        k_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k     = (int'(ptr_i) + i) % NUM_REQ;
            k_idx = k[IDX_W-1:0];
            if (!found && req_i[k_idx]) begin
                found        = 1'b1;
                win_o[k_idx] = 1'b1;
                idx_o        = k_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx serializer between
// NUM_REQ byte producers. Optional ownership lock across multi-byte
// frames is enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int               IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;

    logic [NUM_REQ-1:0]  pick_req, pick_win;
    logic [IDX_W-1:0]    pick_ptr, pick_idx;

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic last_q, last_d;

    // While locked only the owner is a candidate; once the owner drops req the search restarts from it.
    always_comb begin
        pick_req = bus.req;
        pick_ptr = ptr_q;
        if (lock_q) begin
            pick_ptr = owner_q;
            if (bus.req[owner_q]) pick_req = NUM_REQ'(1) << owner_q;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
    assign pick_req    = bus.req;
    assign pick_ptr    = ptr_q;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (pick_req),
        .ptr_i (pick_ptr),
        .win_o (pick_win),
        .idx_o (pick_idx)
    );

    // Sequencer next-state: capture, start handshake, wait for serializer to finish.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = '0;
        tx_data_d = tx_data_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d    = lock_q;
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
                if (lock_q && !bus.req[owner_q]) begin
                    lock_d = 1'b0;
                    ptr_d  = owner_q;
                end
`endif
                if (|pick_req) begin
                    grant_d   = pick_win;
                    owner_d   = pick_idx;
                    tx_data_d = bus.req_data[pick_idx*DATA_W +: DATA_W];
                    state_d   = START;
`ifdef UART_TX_ARB_LOCK_EN
                    last_d    = bus.req_last[pick_idx];
`endif
                end
            end
            START: begin
                state_d = bus.tx_busy ? WAIT_DONE : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    state_d = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                    if (last_q) begin
                        ptr_d  = owner_q;
                        lock_d = 1'b0;
                    end else begin
                        lock_d = 1'b1;
                    end
`else
                    ptr_d   = owner_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset returns to IDLE with requester 0 next in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            tx_data_q <= '0;
            ptr_q     <= PTR_RST;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            tx_data_q <= tx_data_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    // Lock state and the frame-end flag of the byte in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            last_q <= last_d;
        end
    end
`endif

    // Outputs are registers or decodes of the registered state only.
    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = (state_q == START) || (state_q == WAIT_BUSY);
    assign bus.arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx model.
// Expected bytes/acks are queued when requests are driven and compared
// against what the serializer model captured and the acks observed.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int FRAME = 10;

    logic clk = 1'b0;
    logic rst_n;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [DW-1:0]   line_log[$];
    logic [NREQ-1:0] ack_log[$];
    logic [DW-1:0]   exp_data[$];
    logic [NREQ-1:0] exp_ack[$];

    // uart_tx model: accepts tx_start when idle, stays busy FRAME cycles
    logic   ser_busy;
    int     ser_cnt;
    assign bus.tx_busy = ser_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_busy <= 1'b0;
            ser_cnt  <= 0;
        end else if (ser_busy) begin
            if (ser_cnt == 1) ser_busy <= 1'b0;
            ser_cnt <= ser_cnt - 1;
        end else if (bus.tx_start) begin
            ser_busy <= 1'b1;
            ser_cnt  <= FRAME;
            line_log.push_back(bus.tx_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(output logic [NREQ-1:0] a);
        @(negedge clk);
        a = bus.ack;
        if (a != '0) ack_log.push_back(a);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        line_log.delete();
        ack_log.delete();
        exp_data.delete();
        exp_ack.delete();
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] a;
        do_reset();
        n_vec++; if (bus.grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
        n_vec++; if (bus.ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
        n_vec++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        n_vec++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
        n_vec++; if (bus.arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_arb_busy: got %b want 0", bus.arb_busy); end
        repeat (4) step(a);
        n_vec++; if (line_log.size() != 0 || bus.arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_req: bytes %0d busy %b want 0 0", line_log.size(), bus.arb_busy);
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] a;
        logic [DW-1:0]   e8, g8;
        logic [NREQ-1:0] ea, ga;
        int c;
        do_reset();
        bus.req_data[2*DW +: DW] = 8'h55;
        bus.req = 4'b0100;
        exp_data.push_back(8'h55);
        exp_ack.push_back(4'b0100);
        step(a);
        n_vec++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", bus.grant); end
        n_vec++; if (bus.tx_start !== 1'b1) begin n_fail++; $display("FAIL single_tx_start: got %b want 1", bus.tx_start); end
        n_vec++; if (bus.tx_data !== 8'h55) begin n_fail++; $display("FAIL single_tx_data: got %h want 55", bus.tx_data); end
        n_vec++; if (bus.arb_busy !== 1'b1) begin n_fail++; $display("FAIL single_arb_busy: got %b want 1", bus.arb_busy); end
        c = 0;
        while (ack_log.size() < 1 && c < 200) begin step(a); c++; end
        bus.req = '0;
        repeat (5) step(a);
        while (exp_data.size() != 0) begin
            e8 = exp_data.pop_front(); g8 = 'x;
            if (line_log.size() != 0) g8 = line_log.pop_front();
            n_vec++; if (g8 !== e8) begin n_fail++; $display("FAIL single_line: got %h want %h", g8, e8); end
        end
        while (exp_ack.size() != 0) begin
            ea = exp_ack.pop_front(); ga = 'x;
            if (ack_log.size() != 0) ga = ack_log.pop_front();
            n_vec++; if (ga !== ea) begin n_fail++; $display("FAIL single_ack: got %b want %b", ga, ea); end
        end
        n_vec++; if (line_log.size() + ack_log.size() != 0) begin
            n_fail++; $display("FAIL single_extra: bytes %0d acks %0d want 0 0", line_log.size(), ack_log.size());
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] a;
        logic [DW-1:0]   e8, g8;
        logic [NREQ-1:0] ea, ga;
        int c;
        do_reset();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = 8'h10 + DW'(i);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_data.push_back(8'h10 + DW'(i % NREQ));
            exp_ack.push_back(NREQ'(1) << (i % NREQ));
        end
        c = 0;
        while (ack_log.size() < 5 && c < 400) begin step(a); c++; end
        bus.req = '0;
        repeat (5) step(a);
        while (exp_data.size() != 0) begin
            e8 = exp_data.pop_front(); g8 = 'x;
            if (line_log.size() != 0) g8 = line_log.pop_front();
            n_vec++; if (g8 !== e8) begin n_fail++; $display("FAIL rr_line: got %h want %h", g8, e8); end
        end
        while (exp_ack.size() != 0) begin
            ea = exp_ack.pop_front(); ga = 'x;
            if (ack_log.size() != 0) ga = ack_log.pop_front();
            n_vec++; if (ga !== ea) begin n_fail++; $display("FAIL rr_ack: got %b want %b", ga, ea); end
        end
        n_vec++; if (line_log.size() + ack_log.size() != 0) begin
            n_fail++; $display("FAIL rr_extra: bytes %0d acks %0d want 0 0", line_log.size(), ack_log.size());
        end
    endtask

    task automatic test_drop_req();
        logic [NREQ-1:0] a;
        logic [DW-1:0]   e8, g8;
        logic [NREQ-1:0] ea, ga;
        int c;
        do_reset();
        bus.req_data[1*DW +: DW] = 8'hA1;
        bus.req = 4'b0010;
        exp_data.push_back(8'hA1);
        exp_ack.push_back(4'b0010);
        step(a);
        n_vec++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL drop_grant: got %b want 0010", bus.grant); end
        step(a);
        bus.req = '0;
        bus.req_data[1*DW +: DW] = 8'hEE;
        c = 0;
        while (ack_log.size() < 1 && c < 200) begin step(a); c++; end
        repeat (20) step(a);
        n_vec++; if (bus.grant !== 4'b0 || bus.arb_busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_regrant: grant %b busy %b want 0000 0", bus.grant, bus.arb_busy);
        end
        while (exp_data.size() != 0) begin
            e8 = exp_data.pop_front(); g8 = 'x;
            if (line_log.size() != 0) g8 = line_log.pop_front();
            n_vec++; if (g8 !== e8) begin n_fail++; $display("FAIL drop_line: got %h want %h", g8, e8); end
        end
        while (exp_ack.size() != 0) begin
            ea = exp_ack.pop_front(); ga = 'x;
            if (ack_log.size() != 0) ga = ack_log.pop_front();
            n_vec++; if (ga !== ea) begin n_fail++; $display("FAIL drop_ack: got %b want %b", ga, ea); end
        end
        n_vec++; if (line_log.size() + ack_log.size() != 0) begin
            n_fail++; $display("FAIL drop_extra: bytes %0d acks %0d want 0 0", line_log.size(), ack_log.size());
        end
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] a;
        logic [DW-1:0]   e8, g8;
        logic [NREQ-1:0] ea, ga;
        logic [DW-1:0]   s0[3];
        logic            l0[3];
        logic [DW-1:0]   s1[2];
        logic            l1[2];
        int i0, i1, c;
        s0[0] = 8'hB0; s0[1] = 8'hB1; s0[2] = 8'hB2;
        l0[0] = 1'b0;  l0[1] = 1'b0;  l0[2] = 1'b1;
        s1[0] = 8'hC0; s1[1] = 8'hC1;
        l1[0] = 1'b0;  l1[1] = 1'b1;
        do_reset();
        i0 = 0; i1 = 0;
        bus.req_data[0 +: DW]  = s0[0]; bus.req_last[0] = l0[0];
        bus.req_data[DW +: DW] = s1[0]; bus.req_last[1] = l1[0];
        bus.req = 4'b0011;
`ifdef UART_TX_ARB_LOCK_EN
        exp_data = '{8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hC1};
        exp_ack  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
`else
        exp_data = '{8'hB0, 8'hC0, 8'hB1, 8'hC1, 8'hB2};
        exp_ack  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
        c = 0;
        while (ack_log.size() < 5 && c < 600) begin
            step(a);
            c++;
            if (a[0]) begin
                i0++;
                if (i0 < 3) begin bus.req_data[0 +: DW] = s0[i0]; bus.req_last[0] = l0[i0]; end
                else bus.req[0] = 1'b0;
            end
            if (a[1]) begin
                i1++;
                if (i1 < 2) begin bus.req_data[DW +: DW] = s1[i1]; bus.req_last[1] = l1[i1]; end
                else bus.req[1] = 1'b0;
            end
        end
        repeat (5) step(a);
        while (exp_data.size() != 0) begin
            e8 = exp_data.pop_front(); g8 = 'x;
            if (line_log.size() != 0) g8 = line_log.pop_front();
            n_vec++; if (g8 !== e8) begin n_fail++; $display("FAIL lock_line: got %h want %h", g8, e8); end
        end
        while (exp_ack.size() != 0) begin
            ea = exp_ack.pop_front(); ga = 'x;
            if (ack_log.size() != 0) ga = ack_log.pop_front();
            n_vec++; if (ga !== ea) begin n_fail++; $display("FAIL lock_ack: got %b want %b", ga, ea); end
        end
        n_vec++; if (line_log.size() + ack_log.size() != 0) begin
            n_fail++; $display("FAIL lock_extra: bytes %0d acks %0d want 0 0", line_log.size(), ack_log.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] a;
        logic [DW-1:0]   e8, g8;
        logic [NREQ-1:0] ea, ga;
        logic            reached;
        int c;
        do_reset();
        bus.req_data[0 +: DW]    = 8'h20;
        bus.req_data[3*DW +: DW] = 8'h77;
        bus.req = 4'b1000;
        c = 0; reached = 1'b0;
        while (!reached && c < 50) begin
            step(a); c++;
            reached = (bus.grant != '0) && !bus.tx_start && bus.arb_busy;
        end
        n_vec++; if (reached !== 1'b1) begin n_fail++; $display("FAIL mid_reach_wait_done: got %b want 1", reached); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({bus.grant, bus.ack, bus.tx_start, bus.arb_busy} !== 10'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: grant %b ack %b start %b busy %b want all 0",
                               bus.grant, bus.ack, bus.tx_start, bus.arb_busy);
        end
        n_vec++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_tx_data: got %h want 00", bus.tx_data); end
        bus.req = 4'b1001;
        repeat (3) step(a);
        rst_n = 1'b1;
        n_vec++; if (ack_log.size() != 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d acks want 0", ack_log.size()); end
        line_log.delete();
        exp_data = '{8'h20, 8'h77};
        exp_ack  = '{4'b0001, 4'b1000};
        step(a);
        n_vec++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", bus.grant); end
        n_vec++; if (bus.tx_data !== 8'h20) begin n_fail++; $display("FAIL mid_first_data: got %h want 20", bus.tx_data); end
        c = 0;
        while (ack_log.size() < 2 && c < 300) begin
            step(a); c++;
            if (a != '0) bus.req = bus.req & ~a;
        end
        repeat (5) step(a);
        while (exp_data.size() != 0) begin
            e8 = exp_data.pop_front(); g8 = 'x;
            if (line_log.size() != 0) g8 = line_log.pop_front();
            n_vec++; if (g8 !== e8) begin n_fail++; $display("FAIL mid_line: got %h want %h", g8, e8); end
        end
        while (exp_ack.size() != 0) begin
            ea = exp_ack.pop_front(); ga = 'x;
            if (ack_log.size() != 0) ga = ack_log.pop_front();
            n_vec++; if (ga !== ea) begin n_fail++; $display("FAIL mid_ack: got %b want %b", ga, ea); end
        end
        n_vec++; if (line_log.size() + ack_log.size() != 0) begin
            n_fail++; $display("FAIL mid_extra: bytes %0d acks %0d want 0 0", line_log.size(), ack_log.size());
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '1;
        test_reset();
        test_single();
        test_round_robin();
        test_drop_req();
        test_lock();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
